// File: rtl/tms_vram_arbiter_pkg.sv
// Shared types and constants for the VRAM arbiter that sits between the
// vdp18 core and the single-port 16K x 8 VRAM.
package tms_vram_pkg;

  localparam int ADDR_W           = 14;
  localparam int DATA_W           = 8;
  localparam int HOST_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } host_req_t;

endpackage

// File: rtl/tms_vram_arbiter_if.sv
// VDP, host and VRAM pin bundle. The arbiter takes the slave view; the
// environment (core, host, RAM model) takes the master view.
interface tms_vram_arbiter_if;
  import tms_vram_pkg::*;

  logic              ena;
  logic              vdp_we;
  logic [0:ADDR_W-1] vdp_a;
  logic [0:DATA_W-1] vdp_d;
  logic [0:DATA_W-1] vdp_q;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_a;
  logic [DATA_W-1:0] host_d;
  logic              host_ack;
  logic [DATA_W-1:0] host_q;
  logic              host_busy;
  logic              host_timeout;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  ena, vdp_we, vdp_a, vdp_d, host_req, host_we, host_a, host_d, ram_q,
    output vdp_q, host_ack, host_q, host_busy, host_timeout, ram_we, ram_a, ram_d
  );

  modport master (
    output ena, vdp_we, vdp_a, vdp_d, host_req, host_we, host_a, host_d, ram_q,
    input  vdp_q, host_ack, host_q, host_busy, host_timeout, ram_we, ram_a, ram_d
  );

endinterface

// File: rtl/tms_vram_arbiter.sv
// Single-port VRAM arbiter: the VDP owns every ena=1 cycle, a captured host
// request is slotted into the first ena=0 cycle and acked two cycles later.
module tms_vram_arbiter
  import tms_vram_pkg::*;
#(
  parameter int HOST_TIMEOUT = HOST_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                RESET,
  tms_vram_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(HOST_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOST_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  host_req_t         r_req;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_vdp_own;
  logic              r_host_own;
  logic              r_ack;
  logic              r_busy;
  logic              r_timeout;
  logic [DATA_W-1:0] r_vdp_q;
  logic [DATA_W-1:0] r_host_q;
  logic [ADDR_W-1:0] r_ram_a_hold;
  logic [DATA_W-1:0] r_ram_d_hold;

  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_a;
  logic [DATA_W-1:0] w_ram_d;
  logic              w_host_slot;

  // RAM mux: VDP first, then the pending host request; otherwise idle with the bus held.
  always_comb begin
    w_host_slot = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_a     = r_ram_a_hold;
    w_ram_d     = r_ram_d_hold;
    if (bus.ena) begin
      w_ram_we = bus.vdp_we;
      w_ram_a  = bus.vdp_a;
      w_ram_d  = bus.vdp_d;
    end else if (r_state == PEND) begin
      w_host_slot = 1'b1;
      w_ram_we    = r_req.we;
      w_ram_a     = r_req.a;
      w_ram_d     = r_req.d;
    end else begin
      w_host_slot = 1'b0;
    end
  end

  // Next-state logic for the host request FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.host_req ? PEND : IDLE;
      PEND:    w_next = bus.ena ? PEND : WAIT;
      WAIT:    w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, request capture, ownership pipeline and read-data capture.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_cnt        <= '0;
      r_vdp_own    <= 1'b0;
      r_host_own   <= 1'b0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_vdp_q      <= '0;
      r_host_q     <= '0;
      r_ram_a_hold <= '0;
      r_ram_d_hold <= '0;
    end else begin
      r_state      <= w_next;
      r_ram_a_hold <= w_ram_a;
      r_ram_d_hold <= w_ram_d;
      r_ack        <= (w_next == ACK);
      r_busy       <= (w_next == PEND) || (w_next == WAIT);
      // Ownership flags follow issue order, so each ram_q lands in exactly one capture register.
      r_vdp_own    <= bus.ena;
      r_host_own   <= w_host_slot & ~r_req.we;
      if (r_vdp_own) begin
        r_vdp_q <= bus.ram_q;
      end
      if (r_host_own) begin
        r_host_q <= bus.ram_q;
      end
      case (r_state)
        IDLE: begin
          if (bus.host_req) begin
            r_req <= '{we: bus.host_we, a: bus.host_a, d: bus.host_d};
            r_cnt <= '0;
          end
        end
        PEND: begin
          if (bus.ena) begin
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cnt >= CNT_LAST) begin
              r_timeout <= 1'b1;
            end
          end
        end
        WAIT:    r_timeout <= 1'b0;
        ACK:     r_cnt     <= '0;
        default: r_cnt     <= '0;
      endcase
    end
  end

  assign bus.ram_we       = w_ram_we & ~RESET;
  assign bus.ram_a        = w_ram_a;
  assign bus.ram_d        = w_ram_d;
  assign bus.vdp_q        = r_vdp_q;
  assign bus.host_q       = r_host_q;
  assign bus.host_ack     = r_ack;
  assign bus.host_busy    = r_busy;
  assign bus.host_timeout = r_timeout;

endmodule

// File: tb/tb_tms_vram_arbiter.sv
// Directed bench for tms_vram_arbiter: a behavioural VRAM, an ena generator,
// a host driver pushing expected acks into a scoreboard, and an ack monitor.
module tb_tms_vram_arbiter;
  import tms_vram_pkg::*;

  typedef struct {
    bit         is_read;
    logic [7:0] q;
    int         ack_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic RESET = 1'b0;
  int   cyc      = 0;
  int   ena_mode = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] mem [0:16383];

  always #5 clk = ~clk;

  tms_vram_arbiter_if bus();

  tms_vram_arbiter dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  // 1-cycle-latency synchronous VRAM
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
    bus.ram_q <= mem[bus.ram_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ena: mode 0 = every 4th clk, 1 = stuck high, 2 = stuck low
  initial begin
    bus.ena = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      case (ena_mode)
        0:       bus.ena = (cyc % 4 == 3);
        1:       bus.ena = 1'b1;
        default: bus.ena = 1'b0;
      endcase
    end
  end

  // Monitor: VDP ownership in ena cycles, and scoreboard pop on every ack
  initial begin
    forever begin
      @(negedge clk);
      if (!RESET) begin
        if (bus.ena) begin
          chk("vdp_owns_we", 32'(bus.ram_we), 32'(bus.vdp_we));
          chk("vdp_owns_a", 32'(bus.ram_a), 32'(bus.vdp_a));
        end
        if (bus.host_ack) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_read) chk("host_q", 32'(bus.host_q), 32'(mon_e.q));
            if (mon_e.ack_cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
            chk("busy_at_ack", 32'(bus.host_busy), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic align(input int m);
    step();
    for (int i = 0; i < 8 && (cyc % 4 != m); i++) step();
  endtask

  task automatic wait_ack(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.host_ack;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no ack within 1000 cycles, expected one", name);
    end
  endtask

  // Host access; lat < 0 skips the ack-cycle check. Inputs are scrambled after capture.
  task automatic host_op(input bit we, input logic [13:0] a, input logic [7:0] d,
                         input logic [7:0] q, input int lat, input string name);
    exp_t e;
    bus.host_req = 1'b1;
    bus.host_we  = we;
    bus.host_a   = a;
    bus.host_d   = d;
    e.is_read = !we;
    e.q       = q;
    e.ack_cyc = (lat < 0) ? -1 : cyc + lat;
    sb.push_back(e);
    step();
    bus.host_we = !we;
    bus.host_a  = ~a;
    bus.host_d  = ~d;
    wait_ack(name);
    bus.host_req = 1'b0;
  endtask

  initial begin
    bus.vdp_we   = 1'b1;
    bus.vdp_a    = 14'h0800;
    bus.vdp_d    = 8'hFF;
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
    bus.host_a   = 14'h0000;
    bus.host_d   = 8'h00;
    #1 RESET = 1'b1;

    // Reset state, with the VDP trying to write: ram_we must stay low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    end
    chk("rst_host_busy", 32'(bus.host_busy), 32'd0);
    chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
    chk("rst_host_q", 32'(bus.host_q), 32'd0);
    chk("rst_vdp_q", 32'(bus.vdp_q), 32'd0);
    bus.vdp_we = 1'b0;
    step();
    RESET = 1'b0;

    // Preload via host writes
    align(0); host_op(1'b1, 14'h0800, 8'h3C, 8'h00, 3, "preload_0800");
    align(0); host_op(1'b1, 14'h0801, 8'h7E, 8'h00, 3, "preload_0801");

    // 1: write then read back
    align(0); host_op(1'b1, 14'h1234, 8'hA5, 8'h00, 3, "t1_write");
    align(0); host_op(1'b0, 14'h1234, 8'h00, 8'hA5, 3, "t1_read");

    // 2: host slot right after a VDP read slot, then right before one
    align(2); host_op(1'b0, 14'h0801, 8'h00, 8'h7E, 4, "t2_read_after_vdp");
    chk("t2_vdp_q_a", 32'(bus.vdp_q), 32'h3C);
    align(1); host_op(1'b0, 14'h0801, 8'h00, 8'h7E, 3, "t2_read_before_vdp");
    step(); step();
    chk("t2_vdp_q_b", 32'(bus.vdp_q), 32'h3C);

    // 3: request raised in an ena cycle
    align(3); host_op(1'b0, 14'h0800, 8'h00, 8'h3C, 3, "t3_read");
    repeat (8) step();
    chk("t3_single_ack", 32'(sb.size()), 32'd0);

    // 4: ena stuck high -> timeout at 255 stalls, serviced when ena drops
    ena_mode = 1;
    step(); step();
    begin
      exp_t e;
      e.is_read = 1'b1; e.q = 8'h7E; e.ack_cyc = -1;
      sb.push_back(e);
    end
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_a = 14'h0801; bus.host_d = 8'h00;
    repeat (255) step();
    chk("t4_timeout_pre", 32'(bus.host_timeout), 32'd0);
    chk("t4_busy", 32'(bus.host_busy), 32'd1);
    step();
    chk("t4_timeout_set", 32'(bus.host_timeout), 32'd1);
    repeat (44) step();
    chk("t4_timeout_sticky", 32'(bus.host_timeout), 32'd1);
    ena_mode = 2;
    wait_ack("t4_starved_read");
    bus.host_req = 1'b0;
    step();
    chk("t4_timeout_clear", 32'(bus.host_timeout), 32'd0);
    ena_mode = 0;

    // 5: reset in WAIT of a host write
    align(0);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_a = 14'h0010; bus.host_d = 8'h5A;
    step();
    bus.host_req = 1'b0;
    step();
    chk("t5_busy_in_wait", 32'(bus.host_busy), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t5_busy", 32'(bus.host_busy), 32'd0);
    chk("t5_ack", 32'(bus.host_ack), 32'd0);
    chk("t5_host_q", 32'(bus.host_q), 32'd0);
    chk("t5_vdp_q", 32'(bus.vdp_q), 32'd0);
    chk("t5_ram_we", 32'(bus.ram_we), 32'd0);
    repeat (3) step();
    RESET = 1'b0;
    repeat (6) step();
    chk("t5_idle_after", 32'(bus.host_busy), 32'd0);

    // 6: req held high for 4 back-to-back writes
    repeat (12) step();
    align(0);
    bus.host_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      bus.host_we = 1'b1;
      bus.host_a  = 14'h0100 + 14'(i);
      bus.host_d  = 8'hC0 + 8'(i);
      e.is_read = 1'b0; e.q = 8'h00; e.ack_cyc = -1;
      sb.push_back(e);
      wait_ack("t6_write");
      chk("t6_vdp_q", 32'(bus.vdp_q), 32'h3C);
    end
    bus.host_req = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_mem", 32'(mem[14'h0100 + 14'(i)]), 32'(8'hC0 + 8'(i)));
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
